// File: rtl/enc_param_ctrl.sv
// Rotary-encoder parameter editor: browse/select, edit a shadow copy, commit on press.
// Optional step acceleration is enabled by defining ENC_ACCEL_EN.
module enc_param_ctrl #(
  parameter int unsigned NPAR    = 4,
  parameter logic [7:0]  RST_VAL = 8'd8,
  parameter int unsigned TMO     = 1000,
  parameter int unsigned ACC_WIN = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_up,
  input  logic              step_dn,
  input  logic              btn,
  output logic [1:0]        sel,
  output logic              edit,
  output logic [7:0]        cur_val,
  output logic [8*NPAR-1:0] params,
  output logic              upd
);

  localparam int unsigned TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {StBrowse, StEdit, StCommit} state_e;

  state_e          state_q;
  logic            btn_q;
  logic [7:0]      shadow_q;
  logic [TW-1:0]   idle_q;

  logic            press, up, dn;
  logic [1:0]      sel_nxt;
  logic [7:0]      sel_val, sel_nxt_val, delta, shadow_nxt;
  logic [8:0]      sum;

`ifdef ENC_ACCEL_EN
  localparam int unsigned AW = $clog2(ACC_WIN + 1);
  // Cycles left in the acceleration window; non-zero means the last step was recent.
  logic [AW-1:0] acc_q;
  assign delta = (acc_q != '0) ? 8'd4 : 8'd1;
`else
  assign delta = 8'd1;
`endif

  always_comb begin
    press = btn & ~btn_q;
    up    = step_up & ~step_dn;
    dn    = step_dn & ~step_up;

    sel_nxt = sel;
    if (up) begin
      sel_nxt = (sel == 2'(NPAR - 1)) ? 2'd0 : sel + 2'd1;
    end else if (dn) begin
      sel_nxt = (sel == 2'd0) ? 2'(NPAR - 1) : sel - 2'd1;
    end
    sel_val     = params[8*sel +: 8];
    sel_nxt_val = params[8*sel_nxt +: 8];

    sum        = {1'b0, shadow_q} + {1'b0, delta};
    shadow_nxt = shadow_q;
    if (up) begin
      shadow_nxt = sum[8] ? 8'hff : sum[7:0];
    end else if (dn) begin
      shadow_nxt = (shadow_q < delta) ? 8'h00 : shadow_q - delta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StBrowse;
      btn_q    <= 1'b0;
      sel      <= 2'd0;
      edit     <= 1'b0;
      upd      <= 1'b0;
      cur_val  <= RST_VAL;
      params   <= {NPAR{RST_VAL}};
      shadow_q <= RST_VAL;
      idle_q   <= '0;
`ifdef ENC_ACCEL_EN
      acc_q    <= '0;
`endif
    end else begin
      btn_q <= btn;
      upd   <= 1'b0;
`ifdef ENC_ACCEL_EN
      if (acc_q != '0) acc_q <= acc_q - 1'b1;
`endif
      unique case (state_q)
        StBrowse: begin
          if (press) begin
            state_q  <= StEdit;
            edit     <= 1'b1;
            shadow_q <= sel_val;
            cur_val  <= sel_val;
            idle_q   <= '0;
`ifdef ENC_ACCEL_EN
            acc_q    <= '0;
`endif
          end else begin
            sel     <= sel_nxt;
            cur_val <= sel_nxt_val;
          end
        end
        StEdit: begin
          if (press) begin
            // Commit lands on COMMIT entry so upd and the new params appear together.
            state_q             <= StCommit;
            edit                <= 1'b0;
            upd                 <= 1'b1;
            params[8*sel +: 8]  <= shadow_q;
            cur_val             <= shadow_q;
            idle_q              <= '0;
          end else if (up || dn) begin
            shadow_q <= shadow_nxt;
            cur_val  <= shadow_nxt;
            idle_q   <= '0;
`ifdef ENC_ACCEL_EN
            acc_q    <= AW'(ACC_WIN);
`endif
          end else if (idle_q == TW'(TMO - 1)) begin
            state_q <= StBrowse;
            edit    <= 1'b0;
            cur_val <= sel_val;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        StCommit: begin
          state_q <= StBrowse;
        end
        default: begin
          state_q <= StBrowse;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_param_ctrl.sv
// Directed self-checking bench for enc_param_ctrl (default parameters).
module tb_enc_param_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_up = 1'b0;
  logic        step_dn = 1'b0;
  logic        btn = 1'b0;
  logic [1:0]  sel;
  logic        edit;
  logic [7:0]  cur_val;
  logic [31:0] params;
  logic        upd;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;

  enc_param_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .step_up (step_up),
    .step_dn (step_dn),
    .btn     (btn),
    .sel     (sel),
    .edit    (edit),
    .cur_val (cur_val),
    .params  (params),
    .upd     (upd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit is_up, input int gap);
    if (is_up) step_up = 1'b1;
    else step_dn = 1'b1;
    tick();
    step_up = 1'b0;
    step_dn = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic press();
    btn = 1'b1;
    tick();
    btn = 1'b0;
  endtask

  function automatic logic [7:0] prm(input int i);
    return params[8*i +: 8];
  endfunction

  logic [7:0] acc_exp [3];

  initial begin
`ifdef ENC_ACCEL_EN
    acc_exp = '{8'd9, 8'd13, 8'd17};
`else
    acc_exp = '{8'd9, 8'd10, 8'd11};
`endif
    // Reset
    repeat (2) tick();
    rst = 1'b0;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_edit", 32'(edit), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_cur", 32'(cur_val), 32'd8);
    check("rst_params", params, 32'h08080808);

    // Browse wrap
    repeat (4) step(1'b1, 0);
    check("browse_wrap_up", 32'(sel), 32'd0);
    step(1'b1, 0);
    check("browse_sel1", 32'(sel), 32'd1);
    check("browse_edit", 32'(edit), 32'd0);
    check("browse_params", params, 32'h08080808);
    step(1'b0, 0);
    step(1'b0, 0);
    check("browse_wrap_dn", 32'(sel), 32'd3);
    step(1'b1, 0);
    step(1'b1, 0);
    check("browse_back1", 32'(sel), 32'd1);

    // Edit param 1 down to 5 and commit
    upd_cnt = 0;
    press();
    check("edit_enter", 32'(edit), 32'd1);
    check("edit_load", 32'(cur_val), 32'd8);
    repeat (3) step(1'b0, 99);
    check("edit_dn3", 32'(cur_val), 32'd5);
    check("edit_still", 32'(edit), 32'd1);
    press();
    check("commit_upd", 32'(upd), 32'd1);
    check("commit_edit", 32'(edit), 32'd0);
    check("commit_p1", 32'(prm(1)), 32'd5);
    tick();
    check("commit_upd_once", 32'(upd), 32'd0);
    check("commit_upd_cnt", 32'(upd_cnt), 32'd1);
    check("commit_cur", 32'(cur_val), 32'd5);

    // Saturation on param 2
    step(1'b1, 0);
    check("sel2", 32'(sel), 32'd2);
    press();
    repeat (246) step(1'b1, 60);
    check("sat_254", 32'(cur_val), 32'd254);
    press();
    check("sat_commit254", 32'(prm(2)), 32'd254);
    tick();
    press();
    check("sat_reload", 32'(cur_val), 32'd254);
    step(1'b1, 60);
    check("sat_255", 32'(cur_val), 32'd255);
    repeat (3) step(1'b1, 60);
    check("sat_255_held", 32'(cur_val), 32'd255);
    step(1'b0, 0);
    check("sat_dn1", 32'(cur_val), 32'd254);
    repeat (299) step(1'b0, 0);
    check("sat_zero", 32'(cur_val), 32'd0);
    press();
    check("sat_commit0", 32'(prm(2)), 32'd0);
    check("sat_commit_upd", 32'(upd), 32'd1);
    tick();

    // Timeout on param 3
    step(1'b1, 0);
    check("sel3", 32'(sel), 32'd3);
    upd_cnt = 0;
    press();
    step(1'b1, 0);
    step(1'b1, 0);
    check("tmo_shadow", 32'(cur_val), 32'(acc_exp[1] + 8'd0));
    repeat (999) tick();
    check("tmo_before", 32'(edit), 32'd1);
    tick();
    check("tmo_exit", 32'(edit), 32'd0);
    check("tmo_cur", 32'(cur_val), 32'd8);
    check("tmo_param", 32'(prm(3)), 32'd8);
    check("tmo_no_upd", 32'(upd_cnt), 32'd0);

    // Simultaneous inputs
    step_up = 1'b1;
    step_dn = 1'b1;
    tick();
    step_up = 1'b0;
    step_dn = 1'b0;
    check("both_browse", 32'(sel), 32'd3);
    btn = 1'b1;
    step_up = 1'b1;
    tick();
    btn = 1'b0;
    step_up = 1'b0;
    check("press_step_edit", 32'(edit), 32'd1);
    check("press_step_sel", 32'(sel), 32'd3);
    check("press_step_cur", 32'(cur_val), 32'd8);
    step_up = 1'b1;
    step_dn = 1'b1;
    tick();
    step_up = 1'b0;
    step_dn = 1'b0;
    check("both_edit", 32'(cur_val), 32'd8);
    btn = 1'b1;
    step_dn = 1'b1;
    tick();
    btn = 1'b0;
    step_dn = 1'b0;
    check("press_dn_upd", 32'(upd), 32'd1);
    check("press_dn_param", 32'(prm(3)), 32'd8);
    tick();

    // Step size (acceleration dependent)
    press();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 9);
      check($sformatf("accel_%0d", i), 32'(cur_val), 32'(acc_exp[i]));
    end
    press();
    check("accel_commit", 32'(prm(3)), 32'(acc_exp[2]));
    tick();

    // Reset during edit discards shadow
    upd_cnt = 0;
    press();
    step(1'b1, 0);
    check("rstedit_pre", 32'(edit), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstedit_edit", 32'(edit), 32'd0);
    check("rstedit_sel", 32'(sel), 32'd0);
    check("rstedit_params", params, 32'h08080808);
    check("rstedit_cur", 32'(cur_val), 32'd8);
    tick();
    check("rstedit_no_upd", 32'(upd_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enc_param_ctrl.md
ENC_PARAM_CTRL -- requirements
Module: enc_param_ctrl

Interface
REQ-001 SHALL have parameter NPAR, default 4: number of stored parameters (sel width fixed at 2 bits).
REQ-002 SHALL have parameter RST_VAL, default 8'd8: reset value of every stored parameter.
REQ-003 SHALL have parameter TMO, default 1000: edit-mode inactivity timeout in clk cycles.
REQ-004 SHALL have parameter ACC_WIN, default 50: acceleration window in clk cycles (used only with ENC_ACCEL_EN).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port step_up, input, 1, one-cycle increment pulse from the encoder decoder.
REQ-008 SHALL have port step_dn, input, 1, one-cycle decrement pulse.
REQ-009 SHALL have port btn, input, 1, debounced push-button level, high = pressed.
REQ-010 SHALL have port sel, output, 2, currently selected parameter index.
REQ-011 SHALL have port edit, output, 1, high while in EDIT state.
REQ-012 SHALL have port cur_val, output, 8, shadow value in EDIT, else stored value of param[sel].
REQ-013 SHALL have port params, output, 8*NPAR, committed parameters; param[i] at bits [8i+7:8i].
REQ-014 SHALL have port upd, output, 1, one-cycle pulse on commit.

Function
REQ-015 SHALL implement FSM states BROWSE, EDIT, COMMIT; all outputs registered.
REQ-016 SHALL detect a press as a btn 0->1 transition against a registered copy of btn; a held level is one press only.
REQ-017 SHALL ignore any cycle where step_up and step_dn are both high.
REQ-018 BROWSE: step_up sets sel to sel+1 with wrap NPAR-1->0; step_dn sets sel to sel-1 with wrap 0->NPAR-1.
REQ-019 BROWSE + press: next cycle edit=1, state EDIT, shadow loaded from param[sel]; sel is frozen in EDIT.
REQ-020 EDIT: step_up adds 1 to shadow, saturating at 255; step_dn subtracts 1, saturating at 0; no wrap.
REQ-021 EDIT + press: go to COMMIT; step in the same cycle is discarded (press wins).
REQ-022 COMMIT: lasts exactly one cycle; param[sel] <= shadow, upd=1, then BROWSE with edit=0.
REQ-023 upd SHALL pulse on every commit, including when the value is unchanged.
REQ-024 EDIT: idle counter clears on any step or press; at TMO consecutive idle cycles, return to BROWSE without commit, upd stays 0.
REQ-025 cur_val SHALL update the cycle after the causing event (latency 1).

Reset
REQ-026 rst SHALL take effect only on a clk edge and override all other inputs.
REQ-027 On reset: state BROWSE, sel=0, edit=0, upd=0, every param = RST_VAL, shadow = RST_VAL, idle and accel counters = 0, btn history = 0.
REQ-028 Reset during EDIT or COMMIT SHALL discard the shadow; no upd pulse.

Configuration
REQ-029 Macro ENC_ACCEL_EN defined: in EDIT, a step arriving within ACC_WIN cycles of the previous accepted step changes shadow by 4 (saturating); otherwise by 1.
REQ-030 Macro ENC_ACCEL_EN undefined: every step changes shadow by 1; no accel counter is synthesized.

Verification
REQ-031 Reset, 5 step_up pulses in BROWSE -> sel=1 (wrap 3->0 observed), edit=0, params all 8'd8.
REQ-032 Press, 3 step_dn spaced 100 cycles, press -> one cycle COMMIT, upd=1 once, param[sel]=5, edit=0.
REQ-033 Edit param at 8'd254, 4 step_up -> cur_val=255, held; step_dn 300 times -> cur_val=0.
REQ-034 Press, 2 step_up, then 1000 idle cycles -> edit=0, param unchanged at 8, upd never high.
REQ-035 step_up and step_dn same cycle, and press+step same cycle -> step ignored, press honoured.
REQ-036 With ENC_ACCEL_EN: step_up pulses 10 cycles apart from 8 -> 9, 13, 17; without macro -> 9, 10, 11.
